// File: rtl/tc_clk_div_gate.sv
// Glitch-free programmable integer clock divider with clean start/stop.
// clk_o comes straight from a flop (clk_q) except through the scan bypass
// mux. Divisor changes go through a one-deep pending register and are only
// moved into the active divisor on a period boundary or while idle, so a
// period is never cut short or stretched mid-phase.

// Clock mux cell: sel=0 -> clk0_i, sel=1 -> clk1_i.
module tc_clk_mux2 (
   input  logic clk0_i,
   input  logic clk1_i,
   input  logic clk_sel_i,
   output logic clk_o
);

   assign clk_o = clk_sel_i ? clk1_i : clk0_i;

endmodule

// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | stopped, clk_q low, cnt held at 0, pending divisor absorbed
// HIGH  | high phase, floor(N/2) cycles
// LOW   | low phase, N - floor(N/2) cycles; last cycle is the boundary
module tc_clk_div_gate #(
   parameter int unsigned DIV_WIDTH   = 8,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 test_mode_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 div_valid_i,
   output logic                 div_ready_o,
   output logic                 clk_o,
   output logic                 active_o,
   output logic                 edge_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0] div_act_q, div_pend_q;
   logic [DIV_WIDTH-1:0] div_clamp, len_high, len_low;
   logic                 pend_v_q;
   logic                 clk_q, clk_d;
   logic                 edge_q, edge_d;
   logic                 active_q;
   logic                 accept, absorb;
   logic                 high_done, low_done;

   // Divisors below 2 cannot form a high and a low phase; force them to 2.
   assign div_clamp = (div_i < DIV_MIN) ? DIV_MIN : div_i;
   assign len_high  = div_act_q >> 1;
   assign len_low   = div_act_q - len_high;
   assign high_done = (cnt_q == (len_high - ONE));
   assign low_done  = (cnt_q == (len_low - ONE));

   assign div_ready_o = !pend_v_q;
   assign accept      = div_valid_i && !pend_v_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic: a stop request is only honoured at the period boundary.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (en_i)      state_d = ST_HIGH;
         ST_HIGH: if (high_done) state_d = ST_LOW;
         ST_LOW:  if (low_done)  state_d = en_i ? ST_HIGH : ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Per-state outputs: counter, next clock level, edge pulse, divisor absorb.
   always_comb begin
      cnt_d  = cnt_q + ONE;
      clk_d  = 1'b0;
      edge_d = 1'b0;
      absorb = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d  = '0;
            absorb = pend_v_q;
            clk_d  = en_i;
            edge_d = en_i;
         end
         ST_HIGH: begin
            clk_d = !high_done;
            if (high_done) cnt_d = '0;
         end
         ST_LOW: begin
            if (low_done) begin
               cnt_d  = '0;
               absorb = pend_v_q;
               clk_d  = en_i;
               edge_d = en_i;
            end
         end
         default: begin
            cnt_d = '0;
         end
      endcase
   end

   // Datapath registers; accept and absorb are mutually exclusive via pend_v_q.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q      <= '0;
         clk_q      <= 1'b0;
         edge_q     <= 1'b0;
         active_q   <= 1'b0;
         div_act_q  <= DIV_RST;
         div_pend_q <= DIV_RST;
         pend_v_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         clk_q    <= clk_d;
         edge_q   <= edge_d;
         active_q <= (state_d != ST_IDLE);
         if (accept) begin
            div_pend_q <= div_clamp;
            pend_v_q   <= 1'b1;
         end else if (absorb) begin
            pend_v_q <= 1'b0;
         end
         if (absorb) div_act_q <= div_pend_q;
      end
   end

   assign active_o = active_q;
   assign edge_o   = edge_q;

   tc_clk_mux2 u_clk_mux (
      .clk0_i    (clk_q),
      .clk1_i    (clk_i),
      .clk_sel_i (test_mode_i),
      .clk_o     (clk_o)
   );

endmodule

// File: tb/tb_tc_clk_div_gate.sv
// Directed bench for tc_clk_div_gate: start, duty cycle, handshake timing,
// boundary updates, clean stop, clamping, async reset and scan bypass.
module tb_tc_clk_div_gate;

   localparam int DW = 8;

   logic          clk_i       = 1'b0;
   logic          rst_ni      = 1'b0;
   logic          en_i        = 1'b0;
   logic          test_mode_i = 1'b0;
   logic          div_valid_i = 1'b0;
   logic [DW-1:0] div_i       = '0;
   logic          div_ready_o, clk_o, active_o, edge_o;

   int n_total = 0;
   int n_bad   = 0;

   tc_clk_div_gate #(.DIV_WIDTH(DW), .DEFAULT_DIV(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (en_i),
      .test_mode_i (test_mode_i),
      .div_i       (div_i),
      .div_valid_i (div_valid_i),
      .div_ready_o (div_ready_o),
      .clk_o       (clk_o),
      .active_o    (active_o),
      .edge_o      (edge_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Walk one period from cycle index 'first'; cycle 0 is the first high cycle.
   task automatic check_period(input string tag, input int hi, input int lo, input int first);
      for (int i = first; i < hi + lo; i++) begin
         chk({tag, ".clk"},  clk_o,    32'(i < hi));
         chk({tag, ".edge"}, edge_o,   32'(i == 0));
         chk({tag, ".act"},  active_o, 1);
         tick();
      end
   endtask

   // Idle handshake: ready drops for exactly one cycle, then div is active.
   task automatic load_idle(input logic [DW-1:0] d);
      div_i       = d;
      div_valid_i = 1'b1;
      chk("load.rdy0", div_ready_o, 1);
      tick();
      div_valid_i = 1'b0;
      chk("load.rdy1", div_ready_o, 0);
      tick();
      chk("load.rdy2", div_ready_o, 1);
   endtask

   // Enable, run nper periods, drop en_i in the first cycle of the last one.
   task automatic run_div(input string tag, input int hi, input int lo, input int nper);
      en_i = 1'b1;
      tick();
      for (int p = 0; p < nper; p++) begin
         if (p == nper - 1) en_i = 1'b0;
         check_period(tag, hi, lo, 0);
      end
      chk({tag, ".act_end"},  active_o, 0);
      chk({tag, ".clk_end"},  clk_o,    0);
      chk({tag, ".edge_end"}, edge_o,   0);
   endtask

   initial begin
      #200us;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      tick();
      tick();
      chk("rst.clk",  clk_o,       0);
      chk("rst.rdy",  div_ready_o, 1);
      chk("rst.act",  active_o,    0);
      chk("rst.edge", edge_o,      0);
      rst_ni = 1'b1;
      tick();
      chk("idle.clk", clk_o,    0);
      chk("idle.act", active_o, 0);

      // basic run at default divisor 4
      en_i = 1'b1;
      chk("start.act_pre", active_o, 0);
      tick();
      chk("start.clk",  clk_o,    1);
      chk("start.edge", edge_o,   1);
      chk("start.act",  active_o, 1);
      for (int p = 0; p < 3; p++) check_period("basic4", 2, 2, 0);

      // mid-period update to 6 during HIGH, second request 10 stalls
      div_i       = 8'd6;
      div_valid_i = 1'b1;
      chk("upd.c0.rdy", div_ready_o, 1);
      chk("upd.c0.clk", clk_o,       1);
      tick();
      div_i = 8'd10;
      chk("upd.c1.rdy", div_ready_o, 0);
      chk("upd.c1.clk", clk_o,       1);
      tick();
      chk("upd.c2.rdy", div_ready_o, 0);
      chk("upd.c2.clk", clk_o,       0);
      tick();
      chk("upd.c3.rdy", div_ready_o, 0);
      chk("upd.c3.clk", clk_o,       0);
      tick();
      chk("upd.c4.clk",  clk_o,       1);
      chk("upd.c4.edge", edge_o,      1);
      chk("upd.c4.rdy",  div_ready_o, 1);
      tick();
      div_valid_i = 1'b0;
      chk("upd.c5.rdy", div_ready_o, 0);
      check_period("upd6", 3, 3, 1);
      check_period("upd10", 5, 5, 0);

      // queue 8, then clean stop from the first HIGH cycle of the div-8 period
      div_i       = 8'd8;
      div_valid_i = 1'b1;
      tick();
      div_valid_i = 1'b0;
      check_period("d10b", 5, 5, 1);
      en_i = 1'b0;
      check_period("stop8", 4, 4, 0);
      chk("stop8.act",  active_o, 0);
      chk("stop8.edge", edge_o,   0);
      for (int i = 0; i < 4; i++) begin
         chk("stop8.quiet", clk_o, 0);
         tick();
      end

      // odd divisor
      load_idle(8'd5);
      run_div("odd5", 2, 3, 2);

      // clamp limits
      load_idle(8'd0);
      run_div("clamp0", 1, 1, 2);
      load_idle(8'd1);
      run_div("clamp1", 1, 1, 2);
      load_idle(8'd255);
      run_div("clamp255", 127, 128, 1);

      // pending divisor absorbed on the boundary where en_i stops the divider
      load_idle(8'd4);
      en_i = 1'b1;
      tick();
      div_i       = 8'd6;
      div_valid_i = 1'b1;
      tick();
      div_valid_i = 1'b0;
      en_i        = 1'b0;
      check_period("bnd4", 2, 2, 1);
      chk("bnd4.act", active_o, 0);
      run_div("bnd6", 3, 3, 1);

      // asynchronous reset in the middle of a high phase
      load_idle(8'd8);
      en_i = 1'b1;
      tick();
      tick();
      chk("arst.pre_clk", clk_o, 1);
      en_i = 1'b0;
      #2;
      rst_ni = 1'b0;
      #1;
      chk("arst.clk",  clk_o,       0);
      chk("arst.act",  active_o,    0);
      chk("arst.rdy",  div_ready_o, 1);
      chk("arst.edge", edge_o,      0);
      #2;
      rst_ni = 1'b1;
      tick();
      chk("arst.idle_clk", clk_o,    0);
      chk("arst.idle_act", active_o, 0);
      run_div("rst_def4", 2, 2, 2);

      // scan bypass while idle: clk_o follows clk_i
      test_mode_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("tm.hi", clk_o, 1);
         @(negedge clk_i);
         #1;
         chk("tm.lo", clk_o, 0);
      end
      test_mode_i = 1'b0;
      tick();
      chk("tm.off", clk_o, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
